// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: the last-grant state used to
// generate read-valid strobes, the per-cycle grant decision, and the byte
// write-enable width that both requesters and the memory share.
package dmem_port_arbiter_pkg;

  localparam int WE_W = 4;

  typedef enum logic [1:0] {
    L_NONE   = 2'd0,
    L_CPU_RD = 2'd1,
    L_DMA_RD = 2'd2
  } last_state_e;

  typedef enum logic [1:0] {
    G_NONE  = 2'd0,
    G_CPU   = 2'd1,
    G_DMA   = 2'd2,
    G_FORCE = 2'd3
  } grant_e;

  // A forced grant is still a DMA access as far as the memory port is concerned.
  function automatic logic is_dma_grant(input grant_e g);
    return (g == G_DMA) || (g == G_FORCE);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_starve_counter.sv
// Starvation counter for the background requester. It counts consecutive
// cycles in which the DMA asked for the port and was refused, stops counting
// at MAX, and flags when MAX has been reached so the arbiter can force a grant.
module starve_counter #(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [7:0] MaxCount = 8'(MAX);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Clear wins over increment; the count holds once it has reached MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (inc && (cnt_q != MaxCount)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register, cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MaxCount);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter in front of a single-ported synchronous data memory.
// The CPU normally has priority; the DMA loader gets idle cycles and, once it
// has been refused MAX_WAIT times in a row, one forced cycle that stalls the
// CPU. Read data comes straight from the memory one cycle after the grant,
// with a registered valid strobe steering it to whichever side asked.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [WE_W-1:0]   cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic [WE_W-1:0]   dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic [WE_W-1:0]   mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  grant_e      grant;
  last_state_e state_q;
  last_state_e state_d;
  logic        wait_at_max;
  logic        dma_denied;

  // A pending DMA request that did not get the port this cycle is a denial.
  assign dma_denied = dma_req && !dma_gnt;

  starve_counter #(
    .MAX (MAX_WAIT)
  ) u_starve_counter (
    .clk    (clk),
    .rst    (rst),
    .inc    (dma_denied),
    .clr    (!dma_denied),
    .at_max (wait_at_max)
  );

  // Grant decision: starved DMA first, then CPU, then DMA; nothing in reset.
  always_comb begin
    grant = G_NONE;
    if (rst) begin
      if (dma_req && wait_at_max) begin
        grant = G_FORCE;
      end else if (cpu_req) begin
        grant = G_CPU;
      end else if (dma_req) begin
        grant = G_DMA;
      end
    end
  end

  // Steer the granted requester onto the memory port; idle port when no grant.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    if (grant == G_CPU) begin
      mem_en   = 1'b1;
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_din  = cpu_wdata;
    end else if (is_dma_grant(grant)) begin
      mem_en   = 1'b1;
      mem_we   = dma_we;
      mem_addr = dma_addr;
      mem_din  = dma_wdata;
    end
  end

  assign cpu_stall = cpu_req && (grant == G_FORCE);
  assign dma_gnt   = is_dma_grant(grant);

  // Remember who issued a read this cycle so its data can be flagged next cycle.
  always_comb begin
    state_d = L_NONE;
    unique case (grant)
      G_CPU: begin
        if (cpu_we == '0) begin
          state_d = L_CPU_RD;
        end
      end
      G_DMA, G_FORCE: begin
        if (dma_we == '0) begin
          state_d = L_DMA_RD;
        end
      end
      default: begin
        state_d = L_NONE;
      end
    endcase
  end

  // Last-grant state register, forced to L_NONE asynchronously in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= L_NONE;
    end else begin
      state_q <= state_d;
    end
  end

  assign cpu_rvalid = (state_q == L_CPU_RD);
  assign dma_rvalid = (state_q == L_DMA_RD);

  // Both sides see the raw memory output; the valid strobes say whose it is.
  assign cpu_rdata = mem_dout;
  assign dma_rdata = mem_dout;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios followed by
// constrained-random traffic, compared against a cycle-level behavioural model.
module tb_dmem_port_arbiter;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 8;

  logic              clk;
  logic              rst;
  logic              cpu_req;
  logic [3:0]        cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dma_req;
  logic [3:0]        dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  int total = 0;
  int bad   = 0;

  dmem_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte-writable memory with one cycle of read latency.
  logic [DATA_W-1:0] memArr [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) memArr[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      end
      if (mem_we == 4'h0) mem_dout <= memArr[mem_addr];
    end
  end

  // Reference model state: words known to hold a defined value, the
  // consecutive-denial count, and what each side should see next cycle.
  logic [DATA_W-1:0] refMem [int];
  int                denials     = 0;
  logic              expCpuRv    = 1'b0;
  logic              expCpuKnown = 1'b0;
  logic [DATA_W-1:0] expCpuData  = '0;
  logic              expDmaRv    = 1'b0;
  logic              expDmaKnown = 1'b0;
  logic [DATA_W-1:0] expDmaData  = '0;
  logic              lastDmaWin  = 1'b0;

  // One comparison with an immediate assertion; failures are counted and reported.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Model a write into the reference memory; partial writes to unknown words stay unknown.
  task automatic refWrite(input logic [ADDR_W-1:0] a, input logic [3:0] we, input logic [31:0] d);
    logic [31:0] w;
    if (we == 4'hF) begin
      refMem[int'(a)] = d;
    end else if (refMem.exists(int'(a))) begin
      w = refMem[int'(a)];
      for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = d[8*b +: 8];
      refMem[int'(a)] = w;
    end
  endtask

  // Drive one cycle of requests, check every output against the model, advance the model.
  task automatic applyStimulus(
    input logic cr, input logic [3:0] cw, input logic [ADDR_W-1:0] ca, input logic [31:0] cd,
    input logic dr, input logic [3:0] dw, input logic [ADDR_W-1:0] da, input logic [31:0] dd);
    logic forced, cpuWin, dmaWin;
    @(negedge clk);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    #1;
    forced = dr && (denials == MAX_WAIT);
    cpuWin = cr && !forced;
    dmaWin = dr && (forced || !cr);

    checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(expCpuRv));
    if (expCpuRv && expCpuKnown) checkOutput("cpu_rdata", cpu_rdata, expCpuData);
    checkOutput("dma_rvalid", 32'(dma_rvalid), 32'(expDmaRv));
    if (expDmaRv && expDmaKnown) checkOutput("dma_rdata", dma_rdata, expDmaData);

    checkOutput("mem_en", 32'(mem_en), 32'(cpuWin || dmaWin));
    checkOutput("cpu_stall", 32'(cpu_stall), 32'(cr && forced));
    checkOutput("dma_gnt", 32'(dma_gnt), 32'(dmaWin));
    if (cpuWin) begin
      checkOutput("mem_we_cpu", 32'(mem_we), 32'(cw));
      checkOutput("mem_addr_cpu", 32'(mem_addr), 32'(ca));
      checkOutput("mem_din_cpu", mem_din, cd);
    end else if (dmaWin) begin
      checkOutput("mem_we_dma", 32'(mem_we), 32'(dw));
      checkOutput("mem_addr_dma", 32'(mem_addr), 32'(da));
      checkOutput("mem_din_dma", mem_din, dd);
    end else begin
      checkOutput("mem_we_idle", 32'(mem_we), 32'h0);
    end

    expCpuRv = cpuWin && (cw == 4'h0);
    expDmaRv = dmaWin && (dw == 4'h0);
    if (expCpuRv) begin
      expCpuKnown = refMem.exists(int'(ca));
      expCpuData  = expCpuKnown ? refMem[int'(ca)] : '0;
    end
    if (expDmaRv) begin
      expDmaKnown = refMem.exists(int'(da));
      expDmaData  = expDmaKnown ? refMem[int'(da)] : '0;
    end
    if (cpuWin && cw != 4'h0) refWrite(ca, cw, cd);
    if (dmaWin && dw != 4'h0) refWrite(da, dw, dd);

    if (dr && !dmaWin) denials = (denials < MAX_WAIT) ? denials + 1 : MAX_WAIT;
    else denials = 0;
    lastDmaWin = dmaWin;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
  endtask

  // Pulse reset in the middle of a CPU read grant that follows another CPU read.
  task automatic pulseReset(input logic [ADDR_W-1:0] a);
    applyStimulus(1'b1, 4'h0, a, '0, 1'b0, 4'h0, '0, '0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = a; dma_req = 1'b1; dma_we = 4'h0;
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_async_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_dma_gnt", 32'(dma_gnt), 32'h0);
    checkOutput("rst_cpu_stall", 32'(cpu_stall), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_cpu_rvalid_after_edge", 32'(cpu_rvalid), 32'h0);
    checkOutput("rst_dma_rvalid_after_edge", 32'(dma_rvalid), 32'h0);
    checkOutput("rst_mem_en_after_edge", 32'(mem_en), 32'h0);
    @(negedge clk);
    cpu_req = 1'b0; dma_req = 1'b0;
    rst = 1'b1;
    denials  = 0;
    expCpuRv = 1'b0;
    expDmaRv = 1'b0;
  endtask

  // Directed scenarios first, then random traffic with a DMA that holds until granted.
  initial begin
    logic              dmaPending;
    logic [3:0]        rdw, rcw;
    logic [ADDR_W-1:0] rda;
    logic [31:0]       rdd;

    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b1; dma_we = 4'h0; dma_addr = '0; dma_wdata = '0;
    #2;
    checkOutput("reset_mem_en", 32'(mem_en), 32'h0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'h0);
    checkOutput("reset_dma_gnt", 32'(dma_gnt), 32'h0);
    checkOutput("reset_cpu_stall", 32'(cpu_stall), 32'h0);
    checkOutput("reset_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    checkOutput("reset_dma_rvalid", 32'(dma_rvalid), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("reset_cpu_rvalid_edge", 32'(cpu_rvalid), 32'h0);
    @(negedge clk);
    cpu_req = 1'b0; dma_req = 1'b0;
    rst = 1'b1;

    $display("[TB] CPU read / write / read-back");
    applyStimulus(1'b1, 4'h0, 14'h10, '0, 1'b0, 4'h0, '0, '0);
    applyStimulus(1'b1, 4'hF, 14'h10, 32'hDEADBEEF, 1'b0, 4'h0, '0, '0);
    applyStimulus(1'b1, 4'h0, 14'h10, '0, 1'b0, 4'h0, '0, '0);
    idleCycle();
    checkOutput("cpu_readback_rvalid", 32'(cpu_rvalid), 32'h1);
    checkOutput("cpu_readback_data", cpu_rdata, 32'hDEADBEEF);

    $display("[TB] DMA-only read");
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, 4'h0, 14'h3, '0);
    idleCycle();
    checkOutput("dma_read_rvalid_next", 32'(dma_rvalid), 32'h1);
    idleCycle();
    checkOutput("dma_read_rvalid_once", 32'(dma_rvalid), 32'h0);

    $display("[TB] Continuous contention");
    for (int k = 0; k < 27; k++) begin
      applyStimulus(1'b1, 4'h0, ADDR_W'(k), '0, 1'b1, 4'h0, 14'h40, '0);
      checkOutput("contention_stall", 32'(cpu_stall), 32'((k % 9) == 8));
    end
    idleCycle();

    $display("[TB] DMA withdraws after 5 denials");
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 4'h0, 14'h1, '0, 1'b1, 4'h0, 14'h41, '0);
    applyStimulus(1'b1, 4'h0, 14'h1, '0, 1'b0, 4'h0, '0, '0);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 4'h0, 14'h2, '0, 1'b1, 4'h0, 14'h42, '0);
      checkOutput("restart_force", 32'(dma_gnt), 32'(k == 8));
    end
    idleCycle();

    $display("[TB] Reset during CPU read");
    pulseReset(14'h10);
    idleCycle();

    $display("[TB] Byte write merge");
    applyStimulus(1'b1, 4'hF, 14'h20, 32'h11223344, 1'b0, 4'h0, '0, '0);
    applyStimulus(1'b1, 4'h2, 14'h20, 32'h0000AB00, 1'b0, 4'h0, '0, '0);
    applyStimulus(1'b1, 4'h0, 14'h20, '0, 1'b0, 4'h0, '0, '0);
    idleCycle();
    checkOutput("byte_merge_data", cpu_rdata, 32'h1122AB44);

    $display("[TB] Random traffic");
    for (int a = 0; a < 16; a++)
      applyStimulus(1'b1, 4'hF, ADDR_W'(a), $urandom, 1'b0, 4'h0, '0, '0);
    dmaPending = 1'b0;
    rdw = 4'h0; rda = '0; rdd = '0;
    for (int k = 0; k < 400; k++) begin
      if (!dmaPending && ($urandom_range(0, 1) == 1)) begin
        dmaPending = 1'b1;
        rdw = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
        rda = ADDR_W'($urandom_range(0, 15));
        rdd = $urandom;
      end
      rcw = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
      applyStimulus(($urandom_range(0, 9) < 8), rcw, ADDR_W'($urandom_range(0, 15)), $urandom,
                    dmaPending, rdw, rda, rdd);
      if (lastDmaWin) dmaPending = 1'b0;
    end
    idleCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
